// File: rtl/id_pkg.sv
// Shared RV32 decode definitions: base opcodes, immediate formats and opcode classifiers.
package id_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

  function automatic imm_type_e imm_type(input logic [6:0] op);
    imm_type_e t;
    case (op)
      LOAD, OP_IMM, JALR: t = IMM_I;
      STORE:              t = IMM_S;
      BRANCH:             t = IMM_B;
      LUI, AUIPC:         t = IMM_U;
      JAL:                t = IMM_J;
      default:            t = IMM_NONE;
    endcase
    return t;
  endfunction

  // Only R, S and B formats actually read rs2; others must not raise a false hazard.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP) || (op == STORE) || (op == BRANCH);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with hardwired x0 and synchronous clear.
// ID_WB_BYPASS_EN: same-cycle writeback data is forwarded onto the read ports.
module regfile_2r1w
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_wb_en,
  input  logic [AW-1:0]   i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data
);

  logic [XLEN-1:0] r_mem [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) r_mem[k] <= '0;
    end else if (i_wb_en && (i_wb_rd != '0)) begin
      r_mem[i_wb_rd] <= i_wb_data;
    end
  end

  function automatic logic [XLEN-1:0] f_read(input logic [AW-1:0]   addr,
                                             input logic [XLEN-1:0] stored);
    logic [XLEN-1:0] v;
    v = stored;
    if (addr == '0) begin
      v = '0;
`ifdef ID_WB_BYPASS_EN
    end else if (i_wb_en && (i_wb_rd == addr)) begin
      v = i_wb_data;
`endif
    end
    return v;
  endfunction

  always_comb begin
    o_rs1_data = f_read(i_rs1_addr, r_mem[i_rs1_addr]);
    o_rs2_data = f_read(i_rs2_addr, r_mem[i_rs2_addr]);
  end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32 decode stage: field decode, immediate generation, load-use hazard and ID/EX register.
// Optional ID_WB_BYPASS_EN enables writeback-to-read forwarding in the register file.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_rd,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [6:0]      out_opcode,
  output logic            out_is_load
);

  logic [6:0]             w_opcode;
  logic [AW-1:0]          w_rd, w_rs1, w_rs2;
  logic [XLEN-1:0]        w_rs1_data, w_rs2_data;
  logic signed [31:0]     w_imm32;
  logic signed [XLEN-1:0] w_imm;
  logic                   w_hazard, w_in_ready, w_accept;

  logic                   r_vld_p1, r_is_load_p1;
  logic [XLEN-1:0]        r_pc_p1, r_rs1_data_p1, r_rs2_data_p1, r_imm_p1;
  logic [AW-1:0]          r_rd_p1;
  logic [2:0]             r_func3_p1;
  logic [6:0]             r_func7_p1, r_opcode_p1;

  assign w_opcode = in_inst[6:0];
  assign w_rd     = in_inst[7  +: AW];
  assign w_rs1    = in_inst[15 +: AW];
  assign w_rs2    = in_inst[20 +: AW];

  function automatic logic signed [31:0] f_imm(input logic [31:0] i);
    logic signed [31:0] v;
    case (imm_type(i[6:0]))
      IMM_I:   v = {{20{i[31]}}, i[31:20]};
      IMM_S:   v = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   v = {i[31:12], 12'b0};
      IMM_J:   v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

  assign w_imm32 = f_imm(in_inst);
  assign w_imm   = w_imm32;

  regfile_2r1w #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_wb_en    (wb_en),
    .i_wb_rd    (wb_rd),
    .i_wb_data  (wb_data)
  );

  // A load in ID/EX cannot feed a dependent instruction this cycle; insert one bubble.
  assign w_hazard = r_vld_p1 && r_is_load_p1 && (r_rd_p1 != '0) && in_valid &&
                    ((r_rd_p1 == w_rs1) || ((r_rd_p1 == w_rs2) && uses_rs2(w_opcode)));
  assign w_in_ready = (!r_vld_p1 || out_ready) && !w_hazard && !flush;
  assign w_accept   = in_valid && w_in_ready;
  assign in_ready   = w_in_ready;

  // ID/EX register boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1      <= 1'b0;
      r_is_load_p1  <= 1'b0;
      r_pc_p1       <= '0;
      r_rs1_data_p1 <= '0;
      r_rs2_data_p1 <= '0;
      r_imm_p1      <= '0;
      r_rd_p1       <= '0;
      r_func3_p1    <= '0;
      r_func7_p1    <= '0;
      r_opcode_p1   <= '0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1      <= 1'b1;
      r_is_load_p1  <= (w_opcode == LOAD);
      r_pc_p1       <= in_pc;
      r_rs1_data_p1 <= w_rs1_data;
      r_rs2_data_p1 <= w_rs2_data;
      r_imm_p1      <= w_imm;
      r_rd_p1       <= w_rd;
      r_func3_p1    <= in_inst[14:12];
      r_func7_p1    <= in_inst[31:25];
      r_opcode_p1   <= w_opcode;
    end else if (out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign out_valid    = r_vld_p1;
  assign out_is_load  = r_is_load_p1;
  assign out_pc       = r_pc_p1;
  assign out_rs1_data = r_rs1_data_p1;
  assign out_rs2_data = r_rs2_data_p1;
  assign out_imm      = r_imm_p1;
  assign out_rd       = r_rd_p1;
  assign out_func3    = r_func3_p1;
  assign out_func7    = r_func7_p1;
  assign out_opcode   = r_opcode_p1;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios followed by randomized traffic
// compared cycle by cycle against a behavioural decode/pipeline model.
module tb_id_stage_pipe;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready, flush, wb_en, out_valid, out_ready, out_is_load;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc, wb_data, out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [AW-1:0]   wb_rd, out_rd;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7, out_opcode;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rd(out_rd), .out_func3(out_func3), .out_func7(out_func7),
    .out_opcode(out_opcode), .out_is_load(out_is_load)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state: contents of the ID/EX slot and the architectural registers
  bit          m_valid, m_ld;
  logic [31:0] m_pc, m_r1, m_r2, m_imm;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [6:0]  m_f7, m_op;
  logic [31:0] m_rf [NREG];
  logic        obs_ready;

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic signed [11:0] s12;
    logic signed [12:0] s13;
    logic signed [20:0] s21;
    int r;
    r = 0;
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin s12 = i[31:20]; r = s12; end
      7'b0100011: begin s12 = {i[31:25], i[11:7]}; r = s12; end
      7'b1100011: begin s13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; r = s13; end
      7'b0110111, 7'b0010111: r = int'(i & 32'hFFFF_F000);
      7'b1101111: begin s21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; r = s21; end
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit we,
                                           input logic [4:0] wr, input logic [31:0] wd);
    if (a == 0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
    if (we && wr == a) return wd;
`endif
    return m_rf[a];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ld = 0; m_pc = 0; m_r1 = 0; m_r2 = 0; m_imm = 0;
    m_rd = 0; m_f3 = 0; m_f7 = 0; m_op = 0;
    for (int k = 0; k < NREG; k++) m_rf[k] = 0;
  endtask

  // One clock: drive at the falling edge, check ready, advance model, check outputs after posedge.
  task automatic cycle(input logic [31:0] inst, input logic [31:0] pc, input bit iv,
                       input bit ordy, input bit fl, input bit we, input logic [4:0] wr,
                       input logic [31:0] wd);
    logic [6:0] op;
    logic [4:0] rs1, rs2;
    bit hz, rdy;
    in_inst = inst; in_pc = pc; in_valid = iv; out_ready = ordy; flush = fl;
    wb_en = we; wb_rd = wr; wb_data = wd;
    #1;
    op  = inst[6:0];
    rs1 = inst[19:15];
    rs2 = inst[24:20];
    hz  = m_valid && m_ld && m_rd != 0 && iv &&
          (m_rd == rs1 || (m_rd == rs2 && (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011)));
    rdy = (!m_valid || ordy) && !hz && !fl;
    obs_ready = in_ready;
    chk("in_ready", in_ready, rdy);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (fl) m_valid = 0;
      else if (iv && rdy) begin
        m_valid = 1; m_pc = pc; m_op = op; m_ld = (op == 7'b0000011);
        m_rd = inst[11:7]; m_f3 = inst[14:12]; m_f7 = inst[31:25];
        m_imm = ref_imm(inst);
        m_r1 = ref_read(rs1, we, wr, wd);
        m_r2 = ref_read(rs2, we, wr, wd);
      end else if (ordy) m_valid = 0;
      if (we && wr != 0) m_rf[wr] = wd;
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_pc", out_pc, m_pc);
    chk("out_rs1_data", out_rs1_data, m_r1);
    chk("out_rs2_data", out_rs2_data, m_r2);
    chk("out_imm", out_imm, m_imm);
    chk("out_rd", out_rd, m_rd);
    chk("out_func3", out_func3, m_f3);
    chk("out_func7", out_func7, m_f7);
    chk("out_opcode", out_opcode, m_op);
    chk("out_is_load", out_is_load, m_ld);
    @(negedge clk);
  endtask

  localparam logic [31:0] ADDI_X5 = 32'hFFF0_0293;
  localparam logic [31:0] BEQ_X1  = 32'hFE10_8CE3;
  localparam logic [31:0] LW_X3   = 32'h0001_2183;
  localparam logic [31:0] ADD_X4  = 32'h0011_8233;
  localparam logic [31:0] ADD_X8  = 32'h0003_8433;

  initial begin
    logic [6:0]  ops [10];
    logic [31:0] x;
    ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
            7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011, 7'b1110011};
    model_reset();
    rst_n = 1'b0;
    in_valid = 0; in_inst = 0; in_pc = 0; flush = 0; out_ready = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0;
    @(negedge clk);
    cycle(ADDI_X5, 32'h100, 1, 1, 0, 1, 5'd3, 32'h1234);
    cycle(ADDI_X5, 32'h100, 1, 1, 0, 0, 0, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_imm", out_imm, 0);
    rst_n = 1'b1;

    cycle(ADDI_X5, 32'h100, 1, 1, 0, 0, 0, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_imm", out_imm, 32'hFFFF_FFFF);
    chk("t1_rd", out_rd, 5);

    cycle(0, 0, 0, 1, 0, 1, 5'd1, 32'h10);
    cycle(BEQ_X1, 32'h104, 1, 1, 0, 0, 0, 0);
    chk("t2_rs1", out_rs1_data, 32'h10);
    chk("t2_rs2", out_rs2_data, 32'h10);
    chk("t2_imm", out_imm, 32'hFFFF_FFF8);

    cycle(LW_X3, 32'h108, 1, 1, 0, 0, 0, 0);
    chk("t3_load", out_is_load, 1);
    cycle(ADD_X4, 32'h10C, 1, 1, 0, 0, 0, 0);
    chk("t3_stall_rdy", obs_ready, 0);
    chk("t3_bubble", out_valid, 0);
    cycle(ADD_X4, 32'h10C, 1, 1, 0, 0, 0, 0);
    chk("t3_issue_rdy", obs_ready, 1);
    chk("t3_issue_valid", out_valid, 1);
    chk("t3_issue_rd", out_rd, 4);

    repeat (3) begin
      cycle(ADDI_X5, 32'h110, 1, 0, 0, 0, 0, 0);
      chk("t4_hold_rdy", obs_ready, 0);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_pc", out_pc, 32'h10C);
      chk("t4_hold_rd", out_rd, 4);
    end

    cycle(ADDI_X5, 32'h110, 1, 0, 1, 0, 0, 0);
    chk("t5_flush_rdy", obs_ready, 0);
    chk("t5_flush_valid", out_valid, 0);
    cycle(0, 0, 0, 1, 0, 0, 0, 0);
    chk("t5_not_consumed", out_valid, 0);

    cycle(ADD_X8, 32'h200, 1, 1, 0, 1, 5'd7, 32'hA5);
`ifdef ID_WB_BYPASS_EN
    chk("t6_bypass", out_rs1_data, 32'hA5);
`else
    chk("t6_nobypass", out_rs1_data, 32'h0);
`endif
    cycle(ADD_X8, 32'h204, 1, 1, 0, 1, 5'd0, 32'hDEAD);
    chk("t6_x7_written", out_rs1_data, 32'hA5);
    chk("t6_x0_bypass", out_rs2_data, 32'h0);
    cycle(ADD_X8, 32'h208, 1, 1, 0, 0, 0, 0);
    chk("t6_x0_read", out_rs2_data, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      x = $urandom;
      x[6:0]   = ops[$urandom_range(0, 9)];
      x[11:7]  = 5'($urandom_range(0, 7));
      x[19:15] = 5'($urandom_range(0, 7));
      x[24:20] = 5'($urandom_range(0, 7));
      cycle(x, $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
